mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester round-robin memory arbiter with a registered-read response path and a
// zero-fill clear sequencer that takes priority over new grants.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 4,
    parameter int unsigned DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_req,
    output logic              clr_busy,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int unsigned CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StRdWait, StClear} state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic              r_ptr;
    logic              r_owner;
    logic              r_clr_pend;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_rsp0_valid;
    logic              r_rsp1_valid;
    logic [DATA_W-1:0] r_rsp0_rdata;
    logic [DATA_W-1:0] r_rsp1_rdata;

    logic              w_clr_go;
    logic              w_any_req;
    logic              w_grant_idx;
    logic              w_accept;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_cnt_last;

    // A pending or fresh clear blocks any grant in the same IDLE cycle.
    assign w_clr_go   = (r_state == StIdle) && (clr_req || r_clr_pend);
    assign w_any_req  = req0_valid || req1_valid;
    assign w_cnt_last = (r_cnt == CNT_W'(DEPTH - 1));

    always_comb begin
        if (req0_valid && req1_valid) begin
            w_grant_idx = ~r_ptr;
        end else begin
            w_grant_idx = req1_valid;
        end
    end

    assign w_accept    = !reset && (r_state == StIdle) && !w_clr_go && w_any_req;
    assign w_sel_we    = w_grant_idx ? req1_we    : req0_we;
    assign w_sel_addr  = w_grant_idx ? req1_addr  : req0_addr;
    assign w_sel_wdata = w_grant_idx ? req1_wdata : req0_wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_clr_go) begin
                    w_state_next = StClear;
                end else if (w_accept && !w_sel_we) begin
                    w_state_next = StRdWait;
                end
            end
            StRdWait: w_state_next = StIdle;
            StClear:  if (w_cnt_last) w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_din    = '0;
        clr_busy   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    req0_ready = !w_grant_idx;
                    req1_ready = w_grant_idx;
                    mem_we     = w_sel_we;
                    mem_addr   = w_sel_addr;
                    mem_din    = w_sel_wdata;
                end
            end
            StClear: begin
                clr_busy = 1'b1;
                mem_we   = 1'b1;
                mem_addr = ADDR_W'(r_cnt);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr        <= 1'b1;
            r_owner      <= 1'b0;
            r_clr_pend   <= 1'b0;
            r_cnt        <= '0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp0_rdata <= '0;
            r_rsp1_rdata <= '0;
        end else begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            if (w_accept) begin
                r_ptr <= w_grant_idx;
                if (!w_sel_we) begin
                    r_owner <= w_grant_idx;
                end
            end
            // Memory read data is valid in RD_WAIT; capture it for the owner.
            if (r_state == StRdWait) begin
                if (clr_req) begin
                    r_clr_pend <= 1'b1;
                end
                if (r_owner) begin
                    r_rsp1_valid <= 1'b1;
                    r_rsp1_rdata <= mem_dout;
                end else begin
                    r_rsp0_valid <= 1'b1;
                    r_rsp0_rdata <= mem_dout;
                end
            end
            if (w_clr_go) begin
                r_clr_pend <= 1'b0;
            end
            if (r_state == StClear) begin
                r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
            end
        end
    end

    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp0_rdata = r_rsp0_rdata;
    assign rsp1_rdata = r_rsp1_rdata;

endmodule
